// File: rtl/wb_intercon_n.sv
// Single-master Wishbone interconnect with base/mask decode to NSLAVE slaves.
// It returns a registered ack or data and raises an error on a miss or a slave timeout.
module wb_intercon_n #(
  parameter int DW = 32,
  parameter int SW = DW/16,
  parameter int AW = 32,
  parameter int NSLAVE = 4,
  parameter logic [NSLAVE*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVE*AW-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [AW-2:0]        wbm_adr_i,
  input  logic [DW-1:0]        wbm_dat_i,
  input  logic [SW-1:0]        wbm_sel_i,
  input  logic                 wbm_we_i,
  input  logic                 wbm_cyc_i,
  input  logic                 wbm_stb_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic                 wbm_ack_o,
  output logic                 wbm_err_o,
  output logic [AW-2:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [SW-1:0]        wbs_sel_o,
  output logic                 wbs_we_o,
  output logic [NSLAVE-1:0]    wbs_cyc_o,
  output logic [NSLAVE-1:0]    wbs_stb_o,
  input  logic [NSLAVE*DW-1:0] wbs_dat_i,
  input  logic [NSLAVE-1:0]    wbs_ack_i
);

  localparam int SELW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic [AW-1:0]   byte_adr;
  logic            hit;
  logic [SELW-1:0] hit_idx;
  logic            tmo_hit;
  logic [NSLAVE-1:0] slv_sel;

  assign byte_adr = {wbm_adr_i, 1'b0};

  // Scan downwards so the lowest matching window is left as the winner.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NSLAVE - 1; k >= 0; k--) begin
      if ((byte_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = SELW'(k);
      end
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACTIVE: begin
        if (!wbm_cyc_i) begin
          state_d = IDLE;
        end else if (wbs_ack_i[sel_q]) begin
          dat_d   = wbs_dat_i[sel_q*DW +: DW];
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign slv_sel   = (state_q == ACTIVE) ? (NSLAVE'(1) << sel_q) : '0;
  assign wbs_cyc_o = slv_sel;
  assign wbs_stb_o = slv_sel;

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;

  assign wbm_dat_o = dat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Bench for wb_intercon_n: directed and random transfers against a
// transaction-level model of decode, latency, timeout and read data.
module tb_wb_intercon_n;

  localparam int DW  = 32;
  localparam int SW  = 2;
  localparam int AW  = 32;
  localparam int NS  = 4;
  localparam int TMO = 8;

  localparam logic [NS*AW-1:0] BASE =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [NS*AW-1:0] MASK = {NS{32'h0000_F000}};

  int unsigned base_a [NS] = '{32'h2000, 32'h1000, 32'h2000, 32'h3000};
  int unsigned mask_a [NS] = '{32'hF000, 32'hF000, 32'hF000, 32'hF000};

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-2:0]  wbm_adr;
  logic [DW-1:0]  wbm_dat;
  logic [SW-1:0]  wbm_sel;
  logic           wbm_we;
  logic           wbm_cyc;
  logic           wbm_stb;
  logic [DW-1:0]  wbm_dat_o;
  logic           wbm_ack_o;
  logic           wbm_err_o;
  logic [AW-2:0]  wbs_adr_o;
  logic [DW-1:0]  wbs_dat_o;
  logic [SW-1:0]  wbs_sel_o;
  logic           wbs_we_o;
  logic [NS-1:0]  wbs_cyc_o;
  logic [NS-1:0]  wbs_stb_o;
  logic [NS*DW-1:0] wbs_dat_i;
  logic [NS-1:0]  wbs_ack_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_dat;

  wb_intercon_n #(
    .DW(DW), .SW(SW), .AW(AW), .NSLAVE(NS),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .wbm_adr_i(wbm_adr),
    .wbm_dat_i(wbm_dat),
    .wbm_sel_i(wbm_sel),
    .wbm_we_i(wbm_we),
    .wbm_cyc_i(wbm_cyc),
    .wbm_stb_i(wbm_stb),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & mask_a[k]) == base_a[k]) return k;
    return -1;
  endfunction

  // lead = cycles until the DUT is back in IDLE (1 when issued straight after RESP)
  task automatic xfer(input logic [31:0] a, input logic we,
                      input logic [DW-1:0] wd, input int delay,
                      input logic [DW-1:0] rd, input int lead,
                      input string tag);
    int tgt, exp_strb, strb, resp_at, first_i;
    logic exp_ack, got_ack, got_err;
    logic [NS-1:0] oh;
    logic [SW-1:0] sel;
    tgt = ref_decode(a);
    oh  = (tgt >= 0) ? (NS'(1) << tgt) : '0;
    if (tgt < 0) begin
      exp_strb = 0; exp_ack = 1'b0;
    end else if (delay >= 1 && delay <= TMO) begin
      exp_strb = delay; exp_ack = 1'b1;
    end else begin
      exp_strb = TMO; exp_ack = 1'b0;
    end
    sel = SW'($urandom);
    wbm_adr = a[31:1];
    wbm_dat = wd;
    wbm_sel = sel;
    wbm_we  = we;
    wbm_cyc = 1'b1;
    wbm_stb = 1'b1;
    strb = 0; resp_at = -1; first_i = -1;
    got_ack = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o) begin
        resp_at = i;
        got_ack = wbm_ack_o;
        got_err = wbm_err_o;
        check({tag, "_resp_stb"}, 64'(wbs_stb_o), 64'(0));
        break;
      end
      if (wbs_stb_o != '0) begin
        if (strb == 0) begin
          first_i = i;
          check({tag, "_onehot"}, 64'(wbs_stb_o), 64'(oh));
          check({tag, "_cyc"}, 64'(wbs_cyc_o), 64'(oh));
          check({tag, "_bcast"},
                {wbs_adr_o, wbs_we_o, wbs_sel_o, wbs_dat_o[29:0]},
                {a[31:1], we, sel, wd[29:0]});
        end
        strb++;
      end
      wbs_ack_i = (NS'($urandom) & ~oh) |
                  ((strb > 0 && strb == delay) ? oh : '0);
      for (int k = 0; k < NS; k++) wbs_dat_i[k*DW +: DW] = $urandom;
      if (tgt >= 0) wbs_dat_i[tgt*DW +: DW] = rd;
    end
    wbs_ack_i = '0;
    if (exp_strb > 0) check({tag, "_first_strb"}, 64'(first_i), 64'(lead));
    check({tag, "_strb_cnt"}, 64'(strb), 64'(exp_strb));
    check({tag, "_resp_at"}, 64'(resp_at), 64'(lead + exp_strb));
    check({tag, "_ack_err"}, {got_ack, got_err}, {exp_ack, ~exp_ack});
    if (exp_ack) last_dat = rd;
    check({tag, "_dat"}, 64'(wbm_dat_o), 64'(last_dat));
  endtask

  task automatic idle(input string tag);
    wbm_cyc = 1'b0;
    wbm_stb = 1'b0;
    wbs_ack_i = '0;
    @(negedge clk);
    check({tag, "_idle"}, {wbm_ack_o, wbm_err_o, wbs_stb_o}, '0);
  endtask

  initial begin
    int lead;
    logic pending;
    logic [31:0] a;
    logic [3:0] nib;
    rst_n = 1'b0;
    wbm_adr = '0; wbm_dat = '0; wbm_sel = '0; wbm_we = 1'b0;
    wbm_cyc = 1'b0; wbm_stb = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = '0;
    last_dat = '0;
    repeat (2) @(negedge clk);
    check("reset_out", {wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o}, '0);
    check("reset_dat", 64'(wbm_dat_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    xfer(32'h1004, 1'b0, 32'h0, 1, 32'hDEADBEEF, 0, "rd_hit");
    idle("rd_hit");
    xfer(32'h2000, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 0, "overlap");
    idle("overlap");
    xfer(32'hF000, 1'b0, 32'h0, 1, 32'h1111_2222, 0, "miss");
    idle("miss");
    xfer(32'h3000, 1'b0, 32'h0, 0, 32'h3333_4444, 0, "tmo");
    idle("tmo");
    xfer(32'h3008, 1'b0, 32'h0, TMO, 32'h5555_6666, 0, "tmo_edge");
    idle("tmo_edge");

    wbm_adr = 31'h0800; wbm_we = 1'b0; wbm_cyc = 1'b1; wbm_stb = 1'b1;
    @(negedge clk);
    check("abort_stb", 64'(wbs_stb_o), 64'(4'b0010));
    wbm_cyc = 1'b0; wbm_stb = 1'b0;
    @(negedge clk);
    check("abort_drop", 64'(wbs_stb_o), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", {wbm_ack_o, wbm_err_o}, '0);
    end
    check("abort_dat", 64'(wbm_dat_o), 64'(last_dat));

    wbm_adr = 31'h1800; wbm_cyc = 1'b1; wbm_stb = 1'b1;
    @(negedge clk);
    check("rst_pre_stb", 64'(wbs_stb_o), 64'(4'b1000));
    rst_n = 1'b0;
    #1;
    check("rst_mid", {wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o}, '0);
    check("rst_mid_dat", 64'(wbm_dat_o), 64'(0));
    last_dat = '0;
    wbm_cyc = 1'b0; wbm_stb = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    xfer(32'h1008, 1'b0, 32'h0, 3, 32'hCAFE_0001, 0, "post_rst");
    idle("post_rst");

    xfer(32'h2010, 1'b1, 32'hAAAA_5555, 1, 32'h0, 0, "b2b_s0");
    xfer(32'h3020, 1'b1, 32'h1234_5678, 2, 32'h0, 1, "b2b_s3");
    idle("b2b");

    pending = 1'b0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: nib = 4'h1;
        1: nib = 4'h2;
        2: nib = 4'h3;
        3: nib = 4'hF;
        4: nib = 4'h0;
        default: nib = 4'($urandom);
      endcase
      a = {16'($urandom), nib, 12'($urandom) & 12'hFFE};
      if (pending && $urandom_range(0, 1) == 1) begin
        lead = 1;
      end else begin
        if (pending) idle("rnd");
        lead = 0;
      end
      xfer(a, 1'($urandom), $urandom, $urandom_range(0, 10), $urandom,
           lead, "rnd");
      pending = 1'b1;
    end
    idle("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_intercon_n.md
# wb_intercon_n

Parametrised Wishbone shared-bus interconnect connecting one bus master (the moxie core) to NSLAVE slaves. It decodes each master cycle against per-slave base/mask windows and routes it to exactly one slave. It returns a registered ack or data, and generates a bus error for unmapped addresses or slaves that fail to respond within a programmable timeout. It replaces the fixed single-master, no-error interconnect in the muskoka top level.

## Interface
- DW, 32: data width; must be a multiple of 16.
- SW, DW/16: select width, one bit per 16-bit lane.
- AW, 32: byte address width; the address bus is [AW-1:1].
- NSLAVE, 4: number of slave ports, from 1 to 16.
- SLAVE_BASE, all 0: packed NSLAVE*AW; slave k base is bits [k*AW +: AW].
- SLAVE_MASK, all 0: packed NSLAVE*AW; slave k mask, same packing.
- TIMEOUT, 255: maximum ACTIVE cycles before an error; 0 disables the timeout.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- wbm_adr_i  in  AW-1  master address [AW-1:1].
- wbm_dat_i  in  DW  master write data.
- wbm_sel_i  in  SW  master lane select.
- wbm_we_i  in  1  master write enable.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_dat_o  out  DW  read data to master (registered).
- wbm_ack_o  out  1  transfer complete (registered).
- wbm_err_o  out  1  bus error (registered).
- wbs_adr_o  out  AW-1  broadcast address.
- wbs_dat_o  out  DW  broadcast write data.
- wbs_sel_o  out  SW  broadcast select.
- wbs_we_o  out  1  broadcast write enable.
- wbs_cyc_o  out  NSLAVE  per-slave cycle.
- wbs_stb_o  out  NSLAVE  per-slave strobe.
- wbs_dat_i  in  NSLAVE*DW  packed slave read data; slave k is [k*DW +: DW].
- wbs_ack_i  in  NSLAVE  per-slave ack.

## Operation
- **Decode.** Slave k hits when ({wbm_adr_i,1'b0} & MASK[k]) == BASE[k]. If several slaves hit, the lowest k wins. If no slave hits, the cycle is a miss.
- **Broadcast signals.** wbs_adr_o, wbs_dat_o, wbs_sel_o and wbs_we_o are combinational copies of the master inputs. The master holds these stable for the whole cycle.
- **IDLE state.** If wbm_cyc_i & wbm_stb_i:
  - On a hit, latch the winning slave index into sel_q, clear the timeout counter, and go to ACTIVE.
  - On a miss, set err_q and go to RESP.
  - No slave strobe is asserted while in IDLE.
- **ACTIVE state.** wbs_cyc_o[sel_q] and wbs_stb_o[sel_q] are 1; all other bits are 0. These outputs are decoded from the state and sel_q registers only.
  - If wbm_cyc_i = 0 (master abort), go to IDLE. No response is given.
  - Else if wbs_ack_i[sel_q] = 1, capture that slave's data into wbm_dat_o, set ack_q, and go to RESP.
  - Else if TIMEOUT != 0 and the counter equals TIMEOUT-1, set err_q and go to RESP.
  - Otherwise, increment the counter. Its width is $clog2(TIMEOUT+1) and it saturates; it never wraps.
  - Ack takes priority over timeout when both occur in the same cycle.
- **RESP state.** wbm_ack_o or wbm_err_o is 1 for exactly this one cycle; they are never both 1. Next state is IDLE unconditionally.
- **Ignored acks.** wbs_ack_i bits from unselected slaves, or any ack outside ACTIVE, are ignored.
- **Read data.** wbm_dat_o holds its last captured value until the next ack; it is not cleared after RESP. On an error it is unchanged. Write cycles also capture slave data, which the master ignores.

## Timing
- **Reset.** rst_n_i low asynchronously forces the following; reset mid-cycle abandons the transfer with no ack or err:
  - state to IDLE;
  - sel_q, the counter, wbm_ack_o, wbm_err_o and wbm_dat_o to 0;
  - wbs_cyc_o and wbs_stb_o to all 0.
- **Hit latency.** Request seen in IDLE at cycle 0; slave strobe from cycle 1. A slave ack in cycle n gives wbm_ack_o in cycle n+1. Minimum is 3 cycles per transfer (IDLE, ACTIVE, RESP).
- **Miss latency.** wbm_err_o is high in cycle 1.
- **Timeout latency.** The strobe stays high for exactly TIMEOUT cycles (1..TIMEOUT); wbm_err_o is high in cycle TIMEOUT+1.
- **Back-to-back.** A new request is accepted in the IDLE cycle that immediately follows RESP. The master must drop stb or present a new address in the cycle after it sees ack or err.

## Test plan
- **Read hit.** NSLAVE=4, BASE1=0x1000, MASK1=0xF000. Read at 0x1004; slave 1 acks in its first strobe cycle with 0xDEADBEEF. Expect wbs_stb_o=4'b0010 for one cycle; the next cycle gives wbm_ack_o=1 and wbm_dat_o=0xDEADBEEF. Total 3 cycles.
- **Overlap priority.** Slaves 0 and 2 both map 0x2000. An access to 0x2000 strobes only bit 0.
- **Miss.** Access 0xF000 with no window matching. wbm_err_o=1 in cycle 1 and no wbs_stb_o bit is ever asserted.
- **Timeout.** TIMEOUT=8, slave never acks. Expect the strobe high for 8 cycles, then wbm_err_o=1 for one cycle, then IDLE. Repeat with the ack arriving on strobe cycle 8: expect ack, not err.
- **Abort/reset.** Master drops cyc in ACTIVE: the strobe falls next cycle and no ack or err follows. rst_n_i pulsed low mid-ACTIVE: all outputs go to 0 immediately, and the next request decodes normally.
- **Back-to-back writes.** Write slave 0 then slave 3 in successive cycles. Expect the second strobe to begin 1 cycle after the first RESP, and the sel and data broadcasts to match each write.
